sync_pulse_generator: RTL and testbench

SYNC_PULSE_GENERATOR -- requirements
Module: sync_pulse_generator

---
 rtl/sync_pulse_generator.sv | 108 ++++++++++
 tb/tb_sync_pulse_generator.sv | 117 +++++++++++
 2 files changed

// File: rtl/sync_pulse_generator.sv
// Raster timing generator: free-running h/v counters, sync pulses and active-area coordinates.
// Define SYNC_PULSE_ACTIVE_HIGH_EN for active-high hsync_o/vsync_o (default active-low).
module sync_pulse_generator #(
  parameter int TOTAL_COLUMNS          = 800,
  parameter int TOTAL_ROWS             = 525,
  parameter int ACTIVE_COLUMNS         = 640,
  parameter int ACTIVE_ROWS            = 480,
  parameter int FRONT_PORCH_HORIZONTAL = 16,
  parameter int BACK_PORCH_HORIZONTAL  = 48,
  parameter int FRONT_PORCH_VERTICAL   = 10,
  parameter int BACK_PORCH_VERTICAL    = 33
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  output logic                                             hsync_o,
  output logic                                             vsync_o,
  output logic                                             video_en_o,
  output logic [$clog2(ACTIVE_COLUMNS):0]                  x_o,
  output logic [$clog2(ACTIVE_ROWS):0]                     y_o,
  output logic [$clog2(ACTIVE_COLUMNS*ACTIVE_ROWS):0]      pixel_o
);

  localparam int HSYNC_W = TOTAL_COLUMNS - ACTIVE_COLUMNS - FRONT_PORCH_HORIZONTAL - BACK_PORCH_HORIZONTAL;
  localparam int VSYNC_W = TOTAL_ROWS - ACTIVE_ROWS - FRONT_PORCH_VERTICAL - BACK_PORCH_VERTICAL;

  localparam int H_CW = (TOTAL_COLUMNS > 1) ? $clog2(TOTAL_COLUMNS) : 1;
  localparam int V_CW = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;
  localparam int X_W  = $clog2(ACTIVE_COLUMNS) + 1;
  localparam int Y_W  = $clog2(ACTIVE_ROWS) + 1;
  localparam int P_W  = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS) + 1;

  localparam int HS_START = ACTIVE_COLUMNS + FRONT_PORCH_HORIZONTAL;
  localparam int HS_END   = HS_START + HSYNC_W;
  localparam int VS_START = ACTIVE_ROWS + FRONT_PORCH_VERTICAL;
  localparam int VS_END   = VS_START + VSYNC_W;

  localparam logic [H_CW-1:0] H_LAST = H_CW'(TOTAL_COLUMNS - 1);
  localparam logic [V_CW-1:0] V_LAST = V_CW'(TOTAL_ROWS - 1);

  generate
    if (HSYNC_W < 1) begin : g_bad_hsync
      $error("sync_pulse_generator: horizontal sync width must be >= 1");
    end
    if (VSYNC_W < 1) begin : g_bad_vsync
      $error("sync_pulse_generator: vertical sync width must be >= 1");
    end
  endgenerate

  logic [H_CW-1:0] r_h;
  logic [V_CW-1:0] r_v;
  logic [P_W-1:0]  r_pixel;

  logic [31:0] w_h32;
  logic [31:0] w_v32;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_video_en;
  logic        w_hs_pulse;
  logic        w_vs_pulse;

  assign w_h32      = 32'(r_h);
  assign w_v32      = 32'(r_v);
  assign w_h_last   = (r_h == H_LAST);
  assign w_v_last   = (r_v == V_LAST);
  assign w_video_en = (w_h32 < ACTIVE_COLUMNS) && (w_v32 < ACTIVE_ROWS);
  assign w_hs_pulse = (w_h32 >= HS_START) && (w_h32 < HS_END);
  assign w_vs_pulse = (w_v32 >= VS_START) && (w_v32 < VS_END);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_h     <= '0;
      r_v     <= '0;
      r_pixel <= '0;
    end else begin
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v <= '0;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end else begin
        r_h <= r_h + 1'b1;
      end

      // Pixel index tracks v*ACTIVE_COLUMNS+h by counting active clocks; frame wrap wins.
      if (w_h_last && w_v_last) begin
        r_pixel <= '0;
      end else if (w_video_en) begin
        r_pixel <= r_pixel + 1'b1;
      end
    end
  end

  assign video_en_o = w_video_en;
  assign x_o        = w_video_en ? X_W'(w_h32) : '0;
  assign y_o        = w_video_en ? Y_W'(w_v32) : '0;
  assign pixel_o    = w_video_en ? r_pixel : '0;

`ifdef SYNC_PULSE_ACTIVE_HIGH_EN
  assign hsync_o = w_hs_pulse;
  assign vsync_o = w_vs_pulse;
`else
  assign hsync_o = ~w_hs_pulse;
  assign vsync_o = ~w_vs_pulse;
`endif

endmodule

// File: tb/tb_sync_pulse_generator.sv
// Randomised-reset bench for sync_pulse_generator with a reduced raster, checked every clock
// against an arithmetic model of h = n mod TC, v = floor(n/TC) mod TR.
module tb_sync_pulse_generator;

  localparam int TC  = 20;
  localparam int TR  = 14;
  localparam int AC  = 12;
  localparam int AR  = 8;
  localparam int FPH = 2;
  localparam int BPH = 3;
  localparam int FPV = 2;
  localparam int BPV = 2;
  localparam int HSW = TC - AC - FPH - BPH;
  localparam int VSW = TR - AR - FPV - BPV;
  localparam int FRAME = TC * TR;

`ifdef SYNC_PULSE_ACTIVE_HIGH_EN
  localparam bit ACTIVE_HIGH = 1'b1;
`else
  localparam bit ACTIVE_HIGH = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       hsync_o;
  logic       vsync_o;
  logic       video_en_o;
  logic [$clog2(AC):0]    x_o;
  logic [$clog2(AR):0]    y_o;
  logic [$clog2(AC*AR):0] pixel_o;

  int n_tests = 0;
  int n_fail  = 0;

  sync_pulse_generator #(
    .TOTAL_COLUMNS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR),
    .FRONT_PORCH_HORIZONTAL(FPH), .BACK_PORCH_HORIZONTAL(BPH),
    .FRONT_PORCH_VERTICAL(FPV), .BACK_PORCH_VERTICAL(BPV)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .video_en_o(video_en_o),
    .x_o(x_o), .y_o(y_o), .pixel_o(pixel_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs for clock n after reset release, straight from the timing rules.
  task automatic check_point(input int n);
    int  h, v, ex, ey, ep;
    bit  en, hp, vp;
    h  = n % TC;
    v  = (n / TC) % TR;
    en = (h < AC) && (v < AR);
    ex = en ? h : 0;
    ey = en ? v : 0;
    ep = en ? v * AC + h : 0;
    hp = (h >= AC + FPH) && (h < AC + FPH + HSW);
    vp = (v >= AR + FPV) && (v < AR + FPV + VSW);
    chk($sformatf("video_en n=%0d", n), 32'(video_en_o), 32'(en));
    chk($sformatf("x n=%0d", n),        32'(x_o),        32'(ex));
    chk($sformatf("y n=%0d", n),        32'(y_o),        32'(ey));
    chk($sformatf("pixel n=%0d", n),    32'(pixel_o),    32'(ep));
    chk($sformatf("hsync n=%0d", n),    32'(hsync_o),    32'(ACTIVE_HIGH ? hp : !hp));
    chk($sformatf("vsync n=%0d", n),    32'(vsync_o),    32'(ACTIVE_HIGH ? vp : !vp));
  endtask

  task automatic check_reset(input string where);
    chk({"rst_video_en ", where}, 32'(video_en_o), 32'd1);
    chk({"rst_x ", where},        32'(x_o),        32'd0);
    chk({"rst_y ", where},        32'(y_o),        32'd0);
    chk({"rst_pixel ", where},    32'(pixel_o),    32'd0);
    chk({"rst_hsync ", where},    32'(hsync_o),    32'(!ACTIVE_HIGH));
    chk({"rst_vsync ", where},    32'(vsync_o),    32'(!ACTIVE_HIGH));
  endtask

  // Release reset, follow the raster for len clocks, then assert reset asynchronously mid-cycle.
  task automatic run_segment(input int seg, input int len);
    int hold;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check_point(0);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk_i);
      check_point(k);
    end
    #($urandom_range(1, 3));
    reset_i = 1'b1;
    #1;
    check_reset("async");
    hold = $urandom_range(0, 2);
    repeat (hold) @(negedge clk_i);
    check_reset("held");
    $display("[TB] segment %0d: %0d clocks checked, reset at n=%0d held %0d cycles",
             seg, len + 1, len, hold);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_reset("power-up");
    run_segment(0, 3 * FRAME + TC + 5);
    for (int s = 1; s <= 6; s++) begin
      run_segment(s, $urandom_range(1, 2 * FRAME));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
